// File: rtl/surprise_pkg.sv
// Shared definitions for the surprise collision, manager and drawing blocks.
package surprise_pkg;

   localparam int DEFAULT_NUM_SURPRISES = 8;
   localparam int MAX_SURPRISES         = 32;

   typedef logic [MAX_SURPRISES-1:0] surpriseVecT;
   typedef logic [4:0]               surpriseIdxT;

   function automatic int idWidth(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic logic isOneHot(input surpriseVecT v);
      return (v != '0) && ((v & (v - surpriseVecT'(1))) == '0);
   endfunction

   // Only meaningful for a one-hot input; multi-hot inputs OR their indices.
   function automatic surpriseIdxT oneHotToIndex(input surpriseVecT v);
      surpriseIdxT idx;
      idx = '0;
      for (int i = 0; i < MAX_SURPRISES; i++) begin
         if (v[i]) idx = idx | surpriseIdxT'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/surprise_respawn_timer.sv
// One channel's respawn down-counter: load on collection, expire on the 1 -> 0 step.
module surprise_respawn_timer #(
   parameter int CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic load,
   output logic expire
);

   localparam int W = $clog2(CYCLES + 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= W'(CYCLES);
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign expire = (count == W'(1)) && !clear;

endmodule

// File: rtl/surprise_manager.sv
// Surprise enable tracker: clears a surprise when Bumpy hits it, optional respawn,
// level restart, collection event/counter and bus sanity checking.
module surprise_manager
   import surprise_pkg::*;
#(
   parameter int NUM_SURPRISES  = DEFAULT_NUM_SURPRISES,
   parameter int ARM_DELAY      = 2,
   parameter int RESPAWN_EN     = 0,
   parameter int RESPAWN_CYCLES = 1000,
   parameter int COUNT_W        = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 level_start,
   input  logic                                 SHP_bumpySurprise,
   input  logic [NUM_SURPRISES-1:0]             surprise_bus,
   output logic [NUM_SURPRISES-1:0]             enable_all,
   output logic                                 collected_pulse,
   output logic [idWidth(NUM_SURPRISES)-1:0]    collected_id,
   output logic [COUNT_W-1:0]                   collected_count,
   output logic                                 all_collected,
   output logic                                 bus_error
);

   localparam int N     = NUM_SURPRISES;
   localparam int ID_W  = idWidth(NUM_SURPRISES);
   localparam int ARM_W = (ARM_DELAY > 0) ? $clog2(ARM_DELAY + 1) : 1;

   logic [N-1:0]      enableMask;
   logic [N-1:0]      nextMask;
   logic [N-1:0]      acceptVec;
   logic [N-1:0]      expireVec;
   logic [ARM_W-1:0]  armCnt;
   logic              armed;
   surpriseVecT       busWide;
   logic              busOneHot;
   logic              accept;
   logic [ID_W-1:0]   hitId;

   assign armed = (armCnt == ARM_W'(ARM_DELAY));

   always_comb begin
      busWide          = '0;
      busWide[N-1:0]   = surprise_bus;
      busOneHot        = isOneHot(busWide);
      hitId            = ID_W'(oneHotToIndex(busWide));
      // With a one-hot bus, a nonzero AND means the hit surprise is still enabled.
      accept           = armed && SHP_bumpySurprise && busOneHot
                         && (|(surprise_bus & enableMask)) && !level_start;
      acceptVec        = accept ? surprise_bus : '0;
      if (level_start) nextMask = '1;
      else             nextMask = (enableMask | expireVec) & ~acceptVec;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enableMask      <= '1;
         enable_all      <= '1;
         collected_pulse <= 1'b0;
         collected_id    <= '0;
         collected_count <= '0;
         all_collected   <= 1'b0;
         bus_error       <= 1'b0;
         armCnt          <= '0;
      end else begin
         enableMask      <= nextMask;
         enable_all      <= enableMask;
         collected_pulse <= accept;
         all_collected   <= (nextMask == '0);
         bus_error       <= armed && SHP_bumpySurprise && !busOneHot;
         if (!armed) armCnt <= armCnt + ARM_W'(1);
         if (accept) begin
            collected_id <= hitId;
            if (collected_count != '1) collected_count <= collected_count + COUNT_W'(1);
         end
      end
   end

   generate
      if (RESPAWN_EN != 0) begin : gRespawn
         for (genvar i = 0; i < N; i++) begin : gTimer
            surprise_respawn_timer #(
               .CYCLES (RESPAWN_CYCLES)
            ) uTimer (
               .clk    (clk),
               .reset  (reset),
               .clear  (level_start),
               .load   (acceptVec[i]),
               .expire (expireVec[i])
            );
         end
      end else begin : gNoRespawn
         assign expireVec = '0;
      end
   endgenerate

endmodule

// File: doc/surprise_manager.md
Name: surprise_manager

Overview:
- Parametrised successor of the single-bank surprise controller.
- Tracks the enable (visible/collectable) state of NUM_SURPRISES surprises and clears a surprise when Bumpy collides with it.
- New behaviour: strict one-hot validation, per-surprise respawn timers, level restart, a collection event and counter, and an all-collected flag.
- Sits between the collision detector (SHP_bumpySurprise plus surprise_bus) and the surprise drawing/object blocks, which consume enable_all.

Parameters:
- NUM_SURPRISES, 8: number of surprise channels, range 1..32.
- ARM_DELAY, 2: cycles after reset deassertion during which collisions are ignored (power-up guard).
- RESPAWN_EN, 0: 1 = a collected surprise re-enables after RESPAWN_CYCLES; 0 = it stays cleared until level_start.
- RESPAWN_CYCLES, 1000: respawn delay in clk cycles, must be at least 1.
- COUNT_W, 8: width of collected_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- level_start  in  1  one-cycle pulse; restores all surprises
- SHP_bumpySurprise  in  1  collision strobe (level, sampled every cycle)
- surprise_bus  in  NUM_SURPRISES  one-hot ID of the surprise hit
- enable_all  out  NUM_SURPRISES  registered enable mask, bit i = surprise i active
- collected_pulse  out  1  one-cycle pulse on an accepted collection
- collected_id  out  $clog2(NUM_SURPRISES) (min 1)  index of the last accepted surprise, held between events
- collected_count  out  COUNT_W  total accepted collections, saturating
- all_collected  out  1  high while the internal enable mask is all zero
- bus_error  out  1  one-cycle pulse when a strobe arrives with a zero or multi-hot bus

Behaviour:
- Reset (synchronous, active-high) sets:
  - internal enable mask and enable_all to all ones;
  - collected_pulse, collected_id, collected_count, all_collected and bus_error to 0;
  - all timers to 0;
  - arm counter to 0.
- Arming:
  - The arm counter increments each cycle after reset until it reaches ARM_DELAY, then holds.
  - armed = (counter == ARM_DELAY).
  - With ARM_DELAY = 0, the block is armed on the first cycle after reset.
- Collision acceptance, evaluated at cycle t:
  - Requires armed, SHP_bumpySurprise = 1, surprise_bus exactly one-hot with bit i, internal enable[i] = 1, and level_start = 0.
  - On acceptance at t: enable[i] clears at t+1, collected_pulse = 1 at t+1, collected_id = i at t+1, collected_count increments at t+1 (saturates at all ones).
  - enable_all is a one-cycle-delayed copy of the internal mask, so it drops at t+2.
- Rejections:
  - Strobe while armed with a zero or multi-hot bus: bus_error pulses at t+1; no state change.
  - Strobe on an already-cleared surprise: silently ignored, no pulse.
  - Strobe before armed: ignored with no error pulse.
- Held strobe: only the first cycle is accepted, because the bit is already cleared on the following cycle. No re-collection and no double count.
- Respawn (RESPAWN_EN = 1):
  - On acceptance of channel i, timer[i] loads RESPAWN_CYCLES.
  - A nonzero timer decrements each cycle.
  - On the transition 1 -> 0, enable[i] sets on that same clock edge.
  - Different channels respawn and collect independently; a collection on channel j and a respawn on channel i in the same cycle both apply.
- Respawn disabled (RESPAWN_EN = 0): timers are not generated and are tied to 0.
- level_start:
  - Internal mask goes to all ones, timers go to 0, and any same-cycle collision is dropped (level_start wins).
  - collected_count, collected_id and the arm state are preserved.
- all_collected is registered from the internal mask (== 0). It deasserts on respawn or level_start.
- Reset mid-operation: everything returns to the reset values and the ARM_DELAY guard reapplies.

Decomposition:
- Shared package surprise_pkg holds:
  - the default NUM_SURPRISES constant;
  - an ID-width function, max(1, $clog2(N));
  - an is_one_hot function;
  - a one-hot-to-index encoder function.
  - The collision and drawing blocks reuse these.
- Sub-module surprise_respawn_timer holds one channel's down-counter: load, decrement, expire pulse.
  - It is instantiated NUM_SURPRISES times in a generate loop when RESPAWN_EN = 1.

Test Plan:
- Arming guard: reset, then strobe with bus = 8'h01 in the first 2 cycles -> enable_all stays FF and there is no pulse. Strobe at cycle 3 -> collected_pulse and collected_id = 0 next cycle; enable_all = FE two cycles after the strobe; count = 1.
- Bad bus: armed strobe with bus = 8'h00, then 8'h03 -> two bus_error pulses, enable_all stays FF, count stays 0.
- Held strobe and all_collected: hold a strobe for 5 cycles on 8'h80 -> one pulse, count = 1, enable_all = 7F. Collect the remaining 7 -> enable_all = 00, all_collected = 1, count = 8.
- Respawn: RESPAWN_EN = 1, RESPAWN_CYCLES = 4; collect bit 2 -> bit 2 internal low for exactly 4 cycles, then high. Collect bit 5 in the same cycle bit 2 respawns -> both apply.
- level_start precedence: with mask 00 and count = 8, pulse level_start together with a strobe on 8'h01 -> enable_all returns to FF, no collected_pulse, count stays 8.
- Saturation and mid-run reset: COUNT_W = 2, collect 5 times via respawn -> count holds at 3. Assert reset mid-run -> all outputs return to reset values on the next edge.
